// File: rtl/fpga_exunit.sv
// fpga_exunit: execution unit fed by the FPGA-unit reservation station.
// Accepts one op per handshake, evaluates it over LATENCY cycles and
// broadcasts exrslt/exdst/kill_spec for exactly one cycle. Ops carrying a
// speculation tag are squashed on a matching mispredict and lose their
// spec bit on a matching correct prediction.
// Optional build macro FPGA_EXU_OUTREG_EN adds one output register stage on
// the broadcast bus (broadcast latency LATENCY+1, issue_ready timing unchanged).
module fpga_exunit #(
  parameter int LATENCY         = 4,
  parameter int DATA_LEN        = 32,
  parameter int RRF_SEL         = 6,
  parameter int SRC_A_SEL_WIDTH = 2,
  parameter int SRC_B_SEL_WIDTH = 2,
  parameter int FUNCT7_WIDTH    = 7,
  parameter int FUNCT3_WIDTH    = 3,
  parameter int SPECTAG_LEN     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [DATA_LEN-1:0]        ex_src1,
  input  logic [DATA_LEN-1:0]        ex_src2,
  input  logic [DATA_LEN-1:0]        imm,
  input  logic [RRF_SEL-1:0]         rrftag,
  input  logic                       dstval,
  input  logic [SRC_A_SEL_WIDTH-1:0] src_a,
  input  logic [SRC_B_SEL_WIDTH-1:0] src_b,
  input  logic [FUNCT7_WIDTH-1:0]    funct7,
  input  logic [FUNCT3_WIDTH-1:0]    funct3,
  input  logic [SPECTAG_LEN-1:0]     spectag,
  input  logic                       specbit,
  input  logic                       prmiss,
  input  logic                       prsuccess,
  input  logic [SPECTAG_LEN-1:0]     prtag,
  input  logic [SPECTAG_LEN-1:0]     specfixtag,
  output logic [DATA_LEN-1:0]        exrslt,
  output logic [RRF_SEL-1:0]         exdst,
  output logic                       kill_spec,
  output logic                       busy
);

  localparam int CNT_W = 5;
  localparam int POP_W = $clog2(DATA_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  logic [DATA_LEN-1:0]    result_reg;
  logic [RRF_SEL-1:0]     rrftag_reg;
  logic                   dstval_reg;
  logic [SPECTAG_LEN-1:0] spectag_reg;
  logic                   specbit_reg;

  logic [DATA_LEN-1:0]  wb_rslt_reg;
  logic [RRF_SEL-1:0]   wb_dst_reg;

  logic [DATA_LEN-1:0]        op_a, op_b;
  logic [4:0]                 shamt;
  logic [POP_W-1:0]           pop_cnt;
  logic signed [DATA_LEN-1:0] sra_out;
  logic [DATA_LEN-1:0]        alu_out;

  logic accept, new_kill, take_new, new_specbit;
  logic held_kill, held_specbit_next, kill_now;
  logic unused_funct7;

  // funct7 carries only the add/sub and shift-kind modifier in bit 5
  assign unused_funct7 = ^funct7;

  assign issue_ready = (state_reg == IDLE) | (state_reg == WB);
  assign busy        = (state_reg != IDLE);
  assign accept      = issue_valid & issue_ready;

  // An incoming op whose tag is being killed this cycle is dropped at the door
  assign new_kill    = prmiss & specbit & (|(spectag & specfixtag));
  assign take_new    = accept & ~new_kill;
  assign new_specbit = specbit & ~(~prmiss & prsuccess & (spectag == prtag));

  // The held op is squashed by a matching mispredict while in EXEC or WB
  assign held_kill         = prmiss & specbit_reg & (|(spectag_reg & specfixtag)) & (state_reg != IDLE);
  assign held_specbit_next = specbit_reg & ~(~prmiss & prsuccess & (spectag_reg == prtag));

  // Broadcast is valid only in WB, for an op that writes a register and survives
  assign kill_now = (state_reg != WB) | ~dstval_reg | held_kill;

  // Operand selection
  always_comb begin
    op_a  = (src_a == '0) ? ex_src1 : '0;
    op_b  = (src_b == '0) ? ex_src2 : imm;
    shamt = op_b[4:0];
  end

  assign sra_out = $signed(op_a) >>> shamt;

  // Population count of operand A
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      pop_cnt = pop_cnt + POP_W'(op_a[i]);
    end
  end

  // Single-cycle evaluation at issue; the result is then held until broadcast
  always_comb begin
    alu_out = '0;
    case (funct3)
      3'd0: alu_out = funct7[5] ? (op_a - op_b) : (op_a + op_b);
      3'd1: alu_out = op_a << shamt;
      3'd2: alu_out = {{(DATA_LEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'd3: alu_out = {{(DATA_LEN-1){1'b0}}, (op_a < op_b)};
      3'd4: alu_out = op_a ^ op_b;
      3'd5: alu_out = funct7[5] ? DATA_LEN'(sra_out) : (op_a >> shamt);
      3'd6: alu_out = op_a | op_b;
      3'd7: alu_out = DATA_LEN'(pop_cnt);
      default: alu_out = '0;
    endcase
  end

  // Next-state and latency-counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (take_new) begin
          if (LATENCY == 1) begin
            state_next = WB;
          end else begin
            state_next = EXEC;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      EXEC: begin
        if (held_kill) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_W'(1)) begin
          state_next = WB;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      WB: begin
        // A back-to-back issue replaces the op being broadcast
        if (take_new) begin
          if (LATENCY == 1) begin
            state_next = WB;
          end else begin
            state_next = EXEC;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Latch the op at accept; otherwise only the spec bit can change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_reg  <= '0;
      rrftag_reg  <= '0;
      dstval_reg  <= 1'b0;
      spectag_reg <= '0;
      specbit_reg <= 1'b0;
    end else if (take_new) begin
      result_reg  <= alu_out;
      rrftag_reg  <= rrftag;
      dstval_reg  <= dstval;
      spectag_reg <= spectag;
      specbit_reg <= new_specbit;
    end else begin
      specbit_reg <= held_specbit_next;
    end
  end

  // Load the broadcast data on entry to WB so it is valid during WB and held afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_rslt_reg <= '0;
      wb_dst_reg  <= '0;
    end else if (state_next == WB) begin
      wb_rslt_reg <= take_new ? alu_out : result_reg;
      wb_dst_reg  <= take_new ? rrftag  : rrftag_reg;
    end
  end

`ifdef FPGA_EXU_OUTREG_EN
  logic [DATA_LEN-1:0]    out_rslt_reg;
  logic [RRF_SEL-1:0]     out_dst_reg;
  logic                   out_kill_reg;
  logic [SPECTAG_LEN-1:0] out_spectag_reg;
  logic                   out_specbit_reg;

  // Extra output stage; carries the op's speculation state so it can still be killed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_rslt_reg    <= '0;
      out_dst_reg     <= '0;
      out_kill_reg    <= 1'b1;
      out_spectag_reg <= '0;
      out_specbit_reg <= 1'b0;
    end else begin
      out_rslt_reg    <= wb_rslt_reg;
      out_dst_reg     <= wb_dst_reg;
      out_kill_reg    <= kill_now;
      out_spectag_reg <= spectag_reg;
      out_specbit_reg <= held_specbit_next;
    end
  end

  assign exrslt    = out_rslt_reg;
  assign exdst     = out_dst_reg;
  assign kill_spec = out_kill_reg | (prmiss & out_specbit_reg & (|(out_spectag_reg & specfixtag)));
`else
  assign exrslt    = wb_rslt_reg;
  assign exdst     = wb_dst_reg;
  assign kill_spec = kill_now;
`endif

endmodule

// File: doc/fpga_exunit.md
Name: fpga_exunit

Overview:
- Execution-side consumer of the FPGA-unit reservation station.
- Accepts one issued op per handshake and evaluates it over a fixed multi-cycle latency.
- Broadcasts the result on the exrslt/exdst/kill_spec bus that feeds every reservation-station source manager.
- Tracks branch speculation on the in-flight op: squashes it on a mispredict and clears its spec bit on a correct prediction.

Parameters:
- LATENCY, 4: cycles from an accepted issue to the result broadcast. Legal range 1 to 16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- issue_valid  in  1  RS has selected an entry this cycle
- issue_ready  out  1  unit can accept an issue this cycle
- ex_src1  in  DATA_LEN  operand 1
- ex_src2  in  DATA_LEN  operand 2
- imm  in  DATA_LEN  immediate
- rrftag  in  RRF_SEL  destination rename tag
- dstval  in  1  op writes a destination
- src_a  in  SRC_A_SEL_WIDTH  A select: 0 = ex_src1, otherwise zero
- src_b  in  SRC_B_SEL_WIDTH  B select: 0 = ex_src2, otherwise imm
- funct7  in  FUNCT7_WIDTH  op modifier
- funct3  in  FUNCT3_WIDTH  op select
- spectag  in  SPECTAG_LEN  speculation tag of the issued op
- specbit  in  1  issued op is speculative
- prmiss  in  1  branch mispredict
- prsuccess  in  1  branch resolved as correct
- prtag  in  SPECTAG_LEN  tag of the resolved branch
- specfixtag  in  SPECTAG_LEN  mask of tags killed on prmiss
- exrslt  out  DATA_LEN  result data
- exdst  out  RRF_SEL  result destination tag
- kill_spec  out  1  1 = broadcast invalid; RS must ignore it
- busy  out  1  an op is in flight

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, exrslt=0, exdst=0, kill_spec=1, busy=0, issue_ready=1. Reset asserted mid-operation abandons the op with no broadcast.
- Operand select: A = (src_a==0) ? ex_src1 : 0. B = (src_b==0) ? ex_src2 : imm.
- Operations, by funct3:
  - 0: A+B, or A-B when funct7[5]=1
  - 1: A << B[4:0]
  - 2: signed A<B, result 1/0
  - 3: unsigned A<B, result 1/0
  - 4: A^B
  - 5: A >> B[4:0]; arithmetic when funct7[5]=1, logical otherwise
  - 6: A|B
  - 7: popcount(A), zero-extended
- Arithmetic wraps modulo 2^DATA_LEN.
- Result, rrftag, dstval, spectag and specbit are latched at accept. Held operands do not change while in flight.
- Accept condition: issue_valid & issue_ready. issue_ready = (state==IDLE) | (state==WB).
- FSM:
  - IDLE: on accept, go to EXEC with counter=LATENCY-1, or straight to WB if LATENCY=1.
  - EXEC: decrement the counter each cycle; at 1, go to WB.
  - WB: drive the broadcast for exactly one cycle. On accept in the same cycle go to EXEC/WB (back-to-back issue), otherwise go to IDLE.
- Issue-to-broadcast latency is exactly LATENCY cycles.
- Broadcast in WB: exrslt=result, exdst=rrftag, kill_spec = ~dstval. In all other states kill_spec=1, and exrslt/exdst hold their last values.
- busy = (state != IDLE).
- prmiss: if the held op has specbit=1 and (spectag & specfixtag) != 0, it is squashed.
  - In EXEC or WB: go to IDLE; if in WB, kill_spec is forced to 1 that cycle.
  - An op accepted in the same cycle with specbit=1 and a matching tag is dropped (the state stays or returns to IDLE).
- prsuccess with spectag==prtag clears the held specbit. This also applies to an op accepted in the same cycle.
- prmiss takes priority over prsuccess.

Optional Feature:
- Macro: FPGA_EXU_OUTREG_EN.
- Defined: exrslt/exdst/kill_spec pass through one extra output register. Latency becomes LATENCY+1.
  - The registered kill_spec is also forced to 1 if prmiss kills the tag of the op currently in that register.
  - issue_ready timing is unchanged.
- Undefined: the broadcast is driven directly from WB, as described above.

Test Plan:
- Reset deassert → kill_spec=1, busy=0, issue_ready=1.
- LATENCY=4; issue funct3=0, ex_src1=5, ex_src2=7, src_a=0, src_b=0, rrftag=3, dstval=1 at cycle t → at t+4 exrslt=12, exdst=3, kill_spec=0 for exactly one cycle; kill_spec=1 at t+1..t+3.
- funct3=5, funct7[5]=1, A=32'h8000_0000, src_b=1, imm=4 → exrslt=32'hF800_0000. funct3=7, A=32'hFF → exrslt=8.
- Issue specbit=1, spectag=4'b0010; prmiss with specfixtag=4'b0010 at t+2 → no kill_spec=0 pulse, busy=0 at t+3. Repeat with specfixtag=4'b0100 → normal broadcast at t+4.
- Back-to-back: a second issue accepted during the WB cycle of the first → broadcasts exactly LATENCY cycles apart, no lost op. Issue_valid during EXEC → issue_ready=0, not accepted.
- Assert reset during EXEC → outputs return to reset values immediately, and no broadcast follows after reset is released.
